spi_mbox_engine: RTL and testbench
==================================

Name: spi_mbox_engine

Overview:
- SPI-side consumer of the 256x32 command mailbox. Connects to the mailbox's port B.
- The Wishbone side posts commands and sets busy. This engine scans for pending entries and runs one 16-bit SPI master transaction per entry.
- It then writes the result back into the same entry with ready=1 and busy=0, which frees the slot for the Wishbone side.

Parameters:
- ADDR_W, 8, mailbox address width; scan range is 0 .. 2**ADDR_W-1.
- CLK_DIV, 4, clk cycles per SCLK half-period; minimum 2.
- CS_GAP, 2, SCLK half-periods spi_cs_n stays high between transactions.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; 0 parks the engine in IDLE after any transaction in flight completes.
- mem_en  out  1  mailbox port-B enable.
- mem_we  out  1  mailbox port-B write enable.
- mem_addr  out  ADDR_W  mailbox port-B address.
- mem_wdata  out  32  write-back word.
- mem_rdata  in  32  mailbox read data, valid 1 cycle after the read-enable cycle.
- spi_sclk  out  1  SPI clock, mode 0, idles low.
- spi_mosi  out  1  SPI data out, MSB first.
- spi_miso  in  1  SPI data in.
- spi_cs_n  out  1  chip select, active low.
- eng_busy  out  1  high from START through WRBACK.
- done  out  1  one-cycle pulse in the WRBACK cycle.
- done_addr  out  ADDR_W  entry index of the last completed command.

Behaviour:
- Word format (shared package):
  - [31] ready, [30] busy, [29] rnw (1=read), [28:16] reserved.
  - [15:8] data, [7] reserved, [6:0] device register address.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, eng_busy=0, done=0, done_addr=0. Scan pointer=0, FSM=IDLE.
- FSM:
  - IDLE: when enable=1 -> RD.
  - RD: mem_en=1, mem_we=0, mem_addr=ptr, for one cycle -> WAIT.
  - WAIT: mem_en=0 for one cycle, allowing the registered read latency -> CHECK.
  - CHECK: latch mem_rdata into cmd.
    - If cmd[30]=1 and cmd[31]=0 -> START.
    - Otherwise ptr advances and FSM goes to RD, or to IDLE if enable=0.
  - START: spi_cs_n=0, eng_busy=1, load shift register {rnw, addr[6:0], data[7:0]} (16 bits), drive MOSI bit15. Wait CLK_DIV cycles -> SHIFT.
  - SHIFT: 16 SCLK periods, each half-period CLK_DIV clks.
    - Rising edge: sample spi_miso into rx shift register.
    - Falling edge: shift MOSI to the next bit.
    - After the 16th falling edge -> STOP.
  - STOP: hold spi_cs_n=0 one half-period, then spi_cs_n=1 -> GAP.
  - GAP: CS_GAP half-periods with CS high -> WRBACK.
  - WRBACK: single cycle with mem_en=1, mem_we=1, mem_addr=ptr. Also done=1 and done_addr=ptr. mem_wdata is:
    - [31]=1, [30]=0, [29:16]=cmd[29:16], [7:0]=cmd[7:0].
    - [15:8]=rx[7:0] if rnw=1, else cmd[15:8].
    - Then ptr advances -> RD, or IDLE if enable=0.
- Pointer: increments modulo 2**ADDR_W; wraps from 255 to 0 at the default width.
- Round-robin: after WRBACK the scan resumes at ptr+1, never re-reading the same entry immediately.
- Entries with busy=0, or with busy=1 and ready=1 (inconsistent), are skipped without a write.
- The engine never writes an entry it did not find pending. The Wishbone side cannot overwrite a busy entry, so there is no port conflict on that entry.
- MISO is only captured on the 8 rising edges of the second byte. First-byte MISO bits are ignored.
- enable dropped mid-transaction: the transaction and its WRBACK complete, then the FSM goes to IDLE. No truncated SPI frames.
- rst mid-transaction:
  - All outputs return to reset values next cycle; spi_cs_n=1 immediately.
  - The entry keeps busy=1 and is re-executed after the scan restarts at 0.
- Frame length: 16 SCLK periods; START to CS high = (2 + 32)*CLK_DIV clk.

Decomposition:
- Package spi_mbox_pkg:
  - Field positions: BIT_READY=31, BIT_BUSY=30, BIT_RNW=29, DATA_MSB=15, DATA_LSB=8, REGA_MSB=6.
  - FSM state encoding.
  - FRAME_BITS=16.
- Sub-module spi_shift16: SCLK divider, 16-bit TX/RX shift registers, start/done handshake, parameter CLK_DIV. The FSM instantiates one.

Test Plan:
- Empty mailbox, enable=1 -> RD/WAIT/CHECK every 3 cycles; ptr wraps 255->0; spi_cs_n stays 1; no mem_we.
- Entry 5 = 0x4000_A312 (busy, write, data 0xA3, reg 0x12) -> MOSI frame 0x12A3 MSB first. Then WRBACK at address 5 with 0x8000_A312, done=1, done_addr=5.
- Entry 9 = 0x6000_0005 (busy, read, reg 5), slave returns byte 0x5C -> MOSI first byte 0x85, write-back 0xA000_5C05.
- Entries 3 and 200 both pending -> 3 serviced first, then 200. Exactly two frames; CS high ≥ CS_GAP*CLK_DIV clk between them.
- rst asserted at SCLK period 7 of a frame for entry 4 -> spi_cs_n=1 next cycle, no write. After release the entry is re-executed and completes with ready=1.
- enable cleared during SHIFT -> frame completes, WRBACK occurs, FSM reaches IDLE, mem_en stays 0 afterwards.

Source files
------------

// File: rtl/spi_mbox_pkg.sv
// Shared definitions for the SPI-side mailbox engine: word field positions,
// FSM encoding and the write-back word builder.
package spi_mbox_pkg;

  localparam int unsigned BIT_READY  = 31;
  localparam int unsigned BIT_BUSY   = 30;
  localparam int unsigned BIT_RNW    = 29;
  localparam int unsigned DATA_MSB   = 15;
  localparam int unsigned DATA_LSB   = 8;
  localparam int unsigned REGA_MSB   = 6;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned STATE_W    = 4;

  localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [STATE_W-1:0] ST_RD     = 4'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 4'd2;
  localparam logic [STATE_W-1:0] ST_CHECK  = 4'd3;
  localparam logic [STATE_W-1:0] ST_START  = 4'd4;
  localparam logic [STATE_W-1:0] ST_SHIFT  = 4'd5;
  localparam logic [STATE_W-1:0] ST_STOP   = 4'd6;
  localparam logic [STATE_W-1:0] ST_GAP    = 4'd7;
  localparam logic [STATE_W-1:0] ST_WRBACK = 4'd8;

  // Completed entry: ready set, busy cleared, read commands take the returned byte.
  function automatic logic [31:0] wrback_word(input logic [29:0] cmd, input logic [7:0] rx);
    logic [7:0] data;
    data = cmd[BIT_RNW] ? rx : cmd[DATA_MSB:DATA_LSB];
    return {1'b1, 1'b0, cmd[BIT_RNW:16], data, cmd[7:0]};
  endfunction

endpackage

// File: rtl/spi_mbox_engine_shift16.sv
// Mode-0 SPI shifter for one 16-bit frame: one lead half-period with MOSI valid,
// then 16 SCLK periods; only the second byte of MISO is captured.
module spi_shift16
  import spi_mbox_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_data,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic [7:0]  rx_byte,
  output logic        done_c
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned HP_W    = 6;
  localparam int unsigned LAST_HP = 2 * FRAME_BITS;

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [HP_W-1:0]  hp;
  logic [14:0]      tx_sr;
  logic             half_end_c;

  assign half_end_c = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done_c     = half_end_c && (hp == HP_W'(LAST_HP));

  // Half-period 0 is the lead-in; odd half-periods end with a rising edge, even with a falling one.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      hp      <= '0;
      tx_sr   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_byte <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      hp      <= '0;
      sclk    <= 1'b0;
      mosi    <= tx_data[15];
      tx_sr   <= tx_data[14:0];
    end else if (active) begin
      if (half_end_c) begin
        div_cnt <= '0;
        hp      <= hp + HP_W'(1);
        if (hp != '0) begin
          if (hp[0]) begin
            sclk <= 1'b1;
            if (hp > HP_W'(FRAME_BITS)) rx_byte <= {rx_byte[6:0], miso};
          end else begin
            sclk  <= 1'b0;
            mosi  <= tx_sr[14];
            tx_sr <= {tx_sr[13:0], 1'b0};
            if (hp == HP_W'(LAST_HP)) active <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_mbox_engine.sv
// Mailbox port-B consumer: scans for pending entries, runs one SPI frame per
// entry and writes the result back with ready set and busy cleared.
module spi_mbox_engine
  import spi_mbox_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n,
  output logic              eng_busy,
  output logic              done,
  output logic [ADDR_W-1:0] done_addr
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GAP_CYC = CS_GAP * CLK_DIV;

  logic [STATE_W-1:0] state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ADDR_W-1:0]  ptr, ptr_d;
  logic [29:0]        cmd, cmd_d;
  logic               mem_en_d, mem_we_d, spi_cs_n_d, eng_busy_d, done_d;
  logic [ADDR_W-1:0]  mem_addr_d, done_addr_d;
  logic [31:0]        mem_wdata_d;
  logic               pending_c, start_c, shift_done_c;
  logic [15:0]        tx_word_c;
  logic [7:0]         rx_byte;

  assign pending_c = mem_rdata[BIT_BUSY] & ~mem_rdata[BIT_READY];
  assign tx_word_c = {mem_rdata[BIT_RNW], mem_rdata[REGA_MSB:0], mem_rdata[DATA_MSB:DATA_LSB]};
  assign start_c   = (state == ST_CHECK) && pending_c;

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .tx_data (tx_word_c),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .rx_byte (rx_byte),
    .done_c  (shift_done_c)
  );

  // Next state; outputs are then registered as a function of the next state.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cmd_d   = cmd;
    case (state)
      ST_IDLE:  if (enable) state_d = ST_RD;
      ST_RD:    state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_CHECK;
      ST_CHECK: begin
        cmd_d = mem_rdata[BIT_RNW:0];
        if (pending_c) begin
          state_d = ST_START;
        end else begin
          ptr_d   = ptr + ADDR_W'(1);
          state_d = enable ? ST_RD : ST_IDLE;
        end
      end
      ST_START: if (cnt == CNT_W'(CLK_DIV - 1)) state_d = ST_SHIFT;
      ST_SHIFT: if (shift_done_c) state_d = ST_STOP;
      ST_STOP:  if (cnt == CNT_W'(CLK_DIV - 1)) state_d = ST_GAP;
      ST_GAP:   if (cnt == CNT_W'(GAP_CYC - 1)) state_d = ST_WRBACK;
      ST_WRBACK: begin
        ptr_d   = ptr + ADDR_W'(1);
        state_d = enable ? ST_RD : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    cnt_d       = (state_d == state) ? cnt + CNT_W'(1) : '0;
    mem_en_d    = (state_d == ST_RD) || (state_d == ST_WRBACK);
    mem_we_d    = (state_d == ST_WRBACK);
    mem_addr_d  = mem_en_d ? ptr_d : mem_addr;
    mem_wdata_d = mem_we_d ? wrback_word(cmd_d, rx_byte) : mem_wdata;
    spi_cs_n_d  = !(state_d inside {ST_START, ST_SHIFT, ST_STOP});
    eng_busy_d  = state_d inside {ST_START, ST_SHIFT, ST_STOP, ST_GAP, ST_WRBACK};
    done_d      = (state_d == ST_WRBACK);
    done_addr_d = done_d ? ptr_d : done_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      cmd       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      spi_cs_n  <= 1'b1;
      eng_busy  <= 1'b0;
      done      <= 1'b0;
      done_addr <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      cmd       <= cmd_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      spi_cs_n  <= spi_cs_n_d;
      eng_busy  <= eng_busy_d;
      done      <= done_d;
      done_addr <= done_addr_d;
    end
  end

endmodule

// File: tb/tb_spi_mbox_engine.sv
// Directed bench for spi_mbox_engine: mailbox RAM model, SPI slave model and
// bus monitors, with one task per scenario.
module tb_spi_mbox_engine;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CS_GAP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        spi_sclk, spi_mosi, spi_cs_n, eng_busy, done;
  logic        spi_miso = 1'b0;
  logic [7:0]  done_addr;

  logic [31:0] mem [256];
  logic        tb_clr = 1'b0, tb_we = 1'b0;
  logic [7:0]  tb_addr = '0;
  logic [31:0] tb_data = '0;
  logic [15:0] slave_word = '0;

  int checks = 0, errors = 0;
  int writes = 0, frames = 0, done_count = 0, en_count = 0;
  int rise_cnt = 0, frame_rises = 0, lo_run = 0, hi_run = 0, last_lo = 0, last_hi = 0;
  int slv_idx = 15;
  logic [15:0] frame_sr = '0;
  logic [15:0] frame_log [8];
  logic [7:0]  done_log [8];
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  spi_mbox_engine #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
    .eng_busy(eng_busy), .done(done), .done_addr(done_addr)
  );

  always #5 clk = ~clk;

  // Registered-read mailbox RAM with a bench-side write port.
  always @(posedge clk) begin
    if (tb_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor and SPI slave, working on values from the previous cycle.
  always @(posedge clk) begin
    if (mem_en) en_count++;
    if (mem_en && mem_we) writes++;
    if (done) begin done_log[done_count % 8] = done_addr; done_count++; end
    if (spi_cs_n) begin
      if (lo_run != 0) last_lo = lo_run;
      lo_run = 0; hi_run++;
    end else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0; lo_run++;
    end
    if (prev_cs && !spi_cs_n) begin rise_cnt = 0; frame_sr = '0; slv_idx = 15; end
    if (!prev_sclk && spi_sclk && !spi_cs_n) begin frame_sr = {frame_sr[14:0], spi_mosi}; rise_cnt++; end
    if (prev_sclk && !spi_sclk && !spi_cs_n && slv_idx > 0) slv_idx--;
    if (!prev_cs && spi_cs_n) begin frame_log[frames % 8] = frame_sr; frame_rises = rise_cnt; frames++; end
    spi_miso <= slave_word[slv_idx[3:0]];
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    @(negedge clk); tb_clr = 1'b1;
    @(negedge clk); tb_clr = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); tb_addr = a; tb_data = d; tb_we = 1'b1;
    @(negedge clk); tb_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({mem_en, mem_we, spi_sclk, spi_mosi, spi_cs_n, eng_busy, done} !== 7'b0000100) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000100", {mem_en, mem_we, spi_sclk, spi_mosi, spi_cs_n, eng_busy, done}); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h required 00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
    checks++; if (done_addr !== 8'h00) begin errors++; $display("FAIL reset_done_addr: got %h required 00", done_addr); end
    enable = 1'b0; rst = 1'b0;
  endtask

  task automatic test_empty_scan();
    int i, b_wr, b_fr, b_en;
    do_reset(); clear_mem();
    b_wr = writes; b_fr = frames;
    @(negedge clk); enable = 1'b1;
    i = 0; while (mem_en !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    checks++; if (mem_en !== 1'b1 || mem_addr !== 8'd0) begin errors++; $display("FAIL scan_first_rd: got en=%b addr=%0d required en=1 addr=0", mem_en, mem_addr); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL scan_wait_idle_en: got %b required 0", mem_en); end
    repeat (2) @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 8'd1) begin errors++; $display("FAIL scan_period3: got en=%b addr=%0d required en=1 addr=1", mem_en, mem_addr); end
    i = 0; while (!(mem_en === 1'b1 && mem_addr === 8'd255) && i < 1000) begin @(negedge clk); i++; end
    checks++; if (mem_addr !== 8'd255) begin errors++; $display("FAIL scan_reach_255: got %0d required 255", mem_addr); end
    repeat (3) @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 8'd0) begin errors++; $display("FAIL scan_wrap: got en=%b addr=%0d required en=1 addr=0", mem_en, mem_addr); end
    checks++; if (writes - b_wr != 0) begin errors++; $display("FAIL scan_no_write: got %0d writes required 0", writes - b_wr); end
    checks++; if (frames - b_fr != 0 || spi_cs_n !== 1'b1) begin errors++; $display("FAIL scan_no_frame: got %0d frames cs_n=%b required 0 frames cs_n=1", frames - b_fr, spi_cs_n); end
    enable = 1'b0;
    repeat (5) @(negedge clk);
    b_en = en_count;
    repeat (10) @(negedge clk);
    checks++; if (en_count - b_en != 0) begin errors++; $display("FAIL scan_parked: got %0d mem_en cycles required 0", en_count - b_en); end
  endtask

  task automatic run_single(input string name, input logic [7:0] a, input logic [31:0] cmd_w,
                            input logic [15:0] slv, input logic [15:0] exp_frame, input logic [31:0] exp_wb);
    int i, b_wr, b_fr;
    do_reset(); clear_mem(); poke(a, cmd_w); slave_word = slv;
    b_wr = writes; b_fr = frames;
    @(negedge clk); enable = 1'b1;
    i = 0; while (done !== 1'b1 && i < 500) begin @(negedge clk); i++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b required 1", name, done); end
    checks++; if ({mem_en, mem_we, eng_busy} !== 3'b111 || mem_addr !== a) begin
      errors++; $display("FAIL %s_wrback_port: got en/we/busy=%b addr=%0d required 111 addr=%0d", name, {mem_en, mem_we, eng_busy}, mem_addr, a); end
    checks++; if (mem_wdata !== exp_wb) begin errors++; $display("FAIL %s_wdata: got %h required %h", name, mem_wdata, exp_wb); end
    checks++; if (done_addr !== a) begin errors++; $display("FAIL %s_done_addr: got %0d required %0d", name, done_addr, a); end
    @(negedge clk); enable = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b required 0", name, done); end
    checks++; if (frames - b_fr != 1 || frame_log[(frames - 1) % 8] !== exp_frame) begin
      errors++; $display("FAIL %s_mosi: got %0d frames last %h required 1 frame %h", name, frames - b_fr, frame_log[(frames - 1) % 8], exp_frame); end
    checks++; if (frame_rises != 16 || last_lo != 34 * CLK_DIV) begin
      errors++; $display("FAIL %s_frame_len: got %0d rises %0d cs-low clks required 16 and %0d", name, frame_rises, last_lo, 34 * CLK_DIV); end
    checks++; if (writes - b_wr != 1 || mem[a] !== exp_wb) begin
      errors++; $display("FAIL %s_mem: got %0d writes entry %h required 1 write entry %h", name, writes - b_wr, mem[a], exp_wb); end
  endtask

  task automatic test_write_cmd();
    run_single("write", 8'd5, 32'h4000_A312, 16'hFFFF, 16'h12A3, 32'h8000_A312);
  endtask

  task automatic test_read_cmd();
    run_single("read", 8'd9, 32'h6000_0005, 16'hA55C, 16'h8500, 32'hA000_5C05);
  endtask

  task automatic test_back_to_back();
    int i, b_wr, b_fr, b_dc;
    do_reset(); clear_mem();
    poke(8'd3, 32'h4000_1101); poke(8'd200, 32'h6000_0042); slave_word = 16'h003C;
    b_wr = writes; b_fr = frames; b_dc = done_count;
    @(negedge clk); enable = 1'b1;
    i = 0; while (done_count - b_dc < 2 && i < 1500) begin @(negedge clk); i++; end
    enable = 1'b0;
    checks++; if (done_count - b_dc != 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", done_count - b_dc); end
    checks++; if (done_log[b_dc % 8] !== 8'd3 || done_log[(b_dc + 1) % 8] !== 8'd200) begin
      errors++; $display("FAIL b2b_order: got %0d,%0d required 3,200", done_log[b_dc % 8], done_log[(b_dc + 1) % 8]); end
    checks++; if (frames - b_fr != 2) begin errors++; $display("FAIL b2b_frames: got %0d required 2", frames - b_fr); end
    checks++; if (frame_log[b_fr % 8] !== 16'h0111 || frame_log[(b_fr + 1) % 8] !== 16'hC200) begin
      errors++; $display("FAIL b2b_mosi: got %h,%h required 0111,C200", frame_log[b_fr % 8], frame_log[(b_fr + 1) % 8]); end
    checks++; if (last_hi < CS_GAP * CLK_DIV || last_hi != 600) begin
      errors++; $display("FAIL b2b_cs_gap: got %0d clks required 600", last_hi); end
    checks++; if (writes - b_wr != 2) begin errors++; $display("FAIL b2b_writes: got %0d required 2", writes - b_wr); end
    checks++; if (mem[3] !== 32'h8000_1101 || mem[200] !== 32'hA000_3C42) begin
      errors++; $display("FAIL b2b_mem: got %h,%h required 80001101,A0003C42", mem[3], mem[200]); end
  endtask

  task automatic test_reset_mid();
    int i, b_wr, b_dc;
    do_reset(); clear_mem(); poke(8'd4, 32'h4000_7704); slave_word = 16'h0000;
    b_wr = writes;
    @(negedge clk); enable = 1'b1;
    i = 0; while (!(spi_cs_n === 1'b0 && rise_cnt == 7) && i < 400) begin @(negedge clk); i++; end
    checks++; if (spi_cs_n !== 1'b0 || rise_cnt != 7) begin errors++; $display("FAIL mid_reach_period7: got cs_n=%b rises=%0d required 0,7", spi_cs_n, rise_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_release: got %b required 1", spi_cs_n); end
    checks++; if ({spi_sclk, spi_mosi, eng_busy, mem_en, mem_we, done} !== 6'b0) begin
      errors++; $display("FAIL mid_outputs: got %b required 000000", {spi_sclk, spi_mosi, eng_busy, mem_en, mem_we, done}); end
    rst = 1'b0;
    b_dc = done_count;
    checks++; if (writes - b_wr != 0 || mem[4] !== 32'h4000_7704) begin
      errors++; $display("FAIL mid_no_write: got %0d writes entry %h required 0 and 40007704", writes - b_wr, mem[4]); end
    i = 0; while (done !== 1'b1 && i < 500) begin @(negedge clk); i++; end
    checks++; if (done !== 1'b1 || done_addr !== 8'd4 || mem_wdata !== 32'h8000_7704) begin
      errors++; $display("FAIL mid_rerun: got done=%b addr=%0d wdata=%h required 1,4,80007704", done, done_addr, mem_wdata); end
    @(negedge clk); enable = 1'b0;
    checks++; if (mem[4] !== 32'h8000_7704 || done_count - b_dc != 1) begin
      errors++; $display("FAIL mid_entry: got %h after %0d completions required 80007704 after 1", mem[4], done_count - b_dc); end
  endtask

  task automatic test_enable_drop();
    int i, b_en;
    do_reset(); clear_mem(); poke(8'd7, 32'h4000_3410); slave_word = 16'h0000;
    @(negedge clk); enable = 1'b1;
    i = 0; while (!(spi_cs_n === 1'b0 && rise_cnt == 3) && i < 400) begin @(negedge clk); i++; end
    checks++; if (eng_busy !== 1'b1) begin errors++; $display("FAIL drop_in_frame: got busy=%b required 1", eng_busy); end
    enable = 1'b0;
    i = 0; while (done !== 1'b1 && i < 400) begin @(negedge clk); i++; end
    checks++; if (done !== 1'b1 || done_addr !== 8'd7 || mem_wdata !== 32'h8000_3410) begin
      errors++; $display("FAIL drop_wrback: got done=%b addr=%0d wdata=%h required 1,7,80003410", done, done_addr, mem_wdata); end
    checks++; if (frame_rises != 16 || last_lo != 34 * CLK_DIV) begin
      errors++; $display("FAIL drop_full_frame: got %0d rises %0d clks required 16 and %0d", frame_rises, last_lo, 34 * CLK_DIV); end
    @(negedge clk);
    b_en = en_count;
    repeat (40) @(negedge clk);
    checks++; if (en_count - b_en != 0) begin errors++; $display("FAIL drop_idle_mem_en: got %0d cycles required 0", en_count - b_en); end
    checks++; if (eng_busy !== 1'b0 || spi_cs_n !== 1'b1) begin
      errors++; $display("FAIL drop_idle_state: got busy=%b cs_n=%b required 0,1", eng_busy, spi_cs_n); end
  endtask

  initial begin
    test_reset();
    test_empty_scan();
    test_write_cmd();
    test_read_cmd();
    test_back_to_back();
    test_reset_mid();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
